// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state encoding, default tap masks and seed helper for the LFSR generator
package lfsr_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    function automatic logic [31:0] default_taps(input int w);
        return (w == 32) ? TAPS_32 : (w == 16) ? 32'(TAPS_16) : 32'(TAPS_8);
    endfunction

    function automatic logic is_zero_seed(input logic [63:0] v);
        return v == '0;
    endfunction

endpackage

// File: rtl/lfsr_random_gen_step.sv
// lfsr_step: one Fibonacci shift plus seed conditioning, both guarded against the all-zero lockup state
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(8'h97)
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] next_val,
    output logic [WIDTH-1:0] seed_val
);

    logic [WIDTH-1:0] shifted;

    assign shifted  = {cur[WIDTH-2:0], ^(cur & TAPS)};
    assign next_val = is_zero_seed(64'(shifted)) ? SEED : shifted;
    assign seed_val = is_zero_seed(64'(seed_in)) ? SEED : seed_in;

endmodule

// File: rtl/lfsr_random_gen.sv
// lfsr_random_gen: on-demand LFSR random source with start/steps run length and rdy/ack handshake
module lfsr_random_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(8'h97),
    parameter int unsigned       CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             ack,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             rdy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] seed_val;

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_step (
        .cur      (lfsr),
        .seed_in  (seed_in),
        .next_val (next_val),
        .seed_val (seed_val)
    );

    // Run FSM: DONE treats start as an implicit ack, RUN ignores every request until the count expires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lfsr  <= SEED;
        end else if (ena) begin
            if (state == RUN) begin
                lfsr <= next_val;
                cnt  <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) state <= DONE;
            end else if (start) begin
                cnt   <= steps;
                state <= (steps == '0) ? DONE : RUN;
            end else if (state == IDLE && seed_load) begin
                lfsr <= seed_val;
            end else if (state == DONE && ack) begin
                state <= IDLE;
            end
        end
    end

    assign value = lfsr;
    assign busy  = state == RUN;
    assign rdy   = state == DONE;

endmodule

// File: tb/tb_lfsr_random_gen.sv
// tb_lfsr_random_gen: directed checks of the LFSR generator with hand-computed sequences
module tb_lfsr_random_gen;

    logic       clk = 0;
    logic       rst = 0;
    logic       ena = 1;
    logic       start = 0;
    logic [3:0] steps = 0;
    logic       ack = 0;
    logic       seed_load = 0;
    logic [7:0] seed_in = 0;
    logic [7:0] value;
    logic       busy;
    logic       rdy;
    int         tests = 0;
    int         fails = 0;

    lfsr_random_gen dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .steps     (steps),
        .ack       (ack),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .value     (value),
        .busy      (busy),
        .rdy       (rdy)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        {start, ack, seed_load, ena} = 4'b0001;
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        tests++; if (value !== 8'h97) begin fails++; $display("FAIL reset_value got %h exp 97", value); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy got %b exp 0", rdy); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_step1();
        apply_reset();
        start = 1; steps = 1;
        @(negedge clk);
        start = 0;
        tests++; if (busy !== 1'b1 || rdy !== 1'b0 || value !== 8'h97) begin fails++; $display("FAIL step1_c1 got busy=%b rdy=%b val=%h exp 1 0 97", busy, rdy, value); end
        @(negedge clk);
        tests++; if (busy !== 1'b0 || rdy !== 1'b1 || value !== 8'h2E) begin fails++; $display("FAIL step1_c2 got busy=%b rdy=%b val=%h exp 0 1 2e", busy, rdy, value); end
        ack = 1;
        @(negedge clk);
        ack = 0;
        tests++; if (rdy !== 1'b0 || busy !== 1'b0 || value !== 8'h2E) begin fails++; $display("FAIL step1_ack got busy=%b rdy=%b val=%h exp 0 0 2e", busy, rdy, value); end
    endtask

    task automatic test_run4();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h2E, 8'h5C, 8'hB8, 8'h70};
        apply_reset();
        start = 1; steps = 4;
        @(negedge clk);
        start = 0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL run4_busy got %b exp 1", busy); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (value !== exp_seq[i] || rdy !== (i == 3)) begin fails++; $display("FAIL run4_seq%0d got val=%h rdy=%b exp %h %b", i, value, rdy, exp_seq[i], i == 3); end
        end
        repeat (2) @(negedge clk);
        tests++; if (rdy !== 1'b1 || value !== 8'h70) begin fails++; $display("FAIL run4_hold got rdy=%b val=%h exp 1 70", rdy, value); end
        ack = 1;
        @(negedge clk);
        ack = 0;
        tests++; if (rdy !== 1'b0 || busy !== 1'b0 || value !== 8'h70) begin fails++; $display("FAIL run4_ack got busy=%b rdy=%b val=%h exp 0 0 70", busy, rdy, value); end
    endtask

    task automatic test_ena_gap();
        logic [7:0] exp_seq [3];
        exp_seq = '{8'h5C, 8'hB8, 8'h70};
        apply_reset();
        start = 1; steps = 4;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        tests++; if (value !== 8'h2E) begin fails++; $display("FAIL gap_first got %h exp 2e", value); end
        ena = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (value !== 8'h2E || busy !== 1'b1 || rdy !== 1'b0) begin fails++; $display("FAIL gap_frozen%0d got val=%h busy=%b rdy=%b exp 2e 1 0", i, value, busy, rdy); end
        end
        ena = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (value !== exp_seq[i] || rdy !== (i == 2)) begin fails++; $display("FAIL gap_seq%0d got val=%h rdy=%b exp %h %b", i, value, rdy, exp_seq[i], i == 2); end
        end
        ena = 0; ack = 1;
        @(negedge clk);
        tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL gap_ack_frozen got rdy=%b exp 1", rdy); end
        ena = 1;
        @(negedge clk);
        ack = 0;
        tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL gap_ack got rdy=%b exp 0", rdy); end
    endtask

    task automatic test_seed();
        apply_reset();
        seed_load = 1; seed_in = 8'h5C;
        @(negedge clk);
        tests++; if (value !== 8'h5C) begin fails++; $display("FAIL seed_load got %h exp 5c", value); end
        seed_in = 8'h00;
        @(negedge clk);
        tests++; if (value !== 8'h97) begin fails++; $display("FAIL seed_zero got %h exp 97", value); end
        ena = 0; seed_in = 8'h33;
        @(negedge clk);
        tests++; if (value !== 8'h97) begin fails++; $display("FAIL seed_ena_low got %h exp 97", value); end
        ena = 1; seed_in = 8'h5C;
        @(negedge clk);
        seed_load = 0;
        start = 1; steps = 2;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        tests++; if (value !== 8'h70 || rdy !== 1'b1) begin fails++; $display("FAIL seed_run2 got val=%h rdy=%b exp 70 1", value, rdy); end
        apply_reset();
        seed_load = 1; seed_in = 8'h11; start = 1; steps = 1;
        @(negedge clk);
        {seed_load, start} = 2'b00;
        @(negedge clk);
        tests++; if (value !== 8'h2E || rdy !== 1'b1) begin fails++; $display("FAIL seed_vs_start got val=%h rdy=%b exp 2e 1", value, rdy); end
        seed_load = 1; seed_in = 8'h11;
        @(negedge clk);
        seed_load = 0;
        tests++; if (value !== 8'h2E || rdy !== 1'b1) begin fails++; $display("FAIL seed_in_done got val=%h rdy=%b exp 2e 1", value, rdy); end
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        start = 1; steps = 4;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        rst = 1;
        #1;
        tests++; if (value !== 8'h97 || busy !== 1'b0 || rdy !== 1'b0) begin fails++; $display("FAIL midrst got val=%h busy=%b rdy=%b exp 97 0 0", value, busy, rdy); end
        @(negedge clk);
        rst = 0;
        start = 1; steps = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        tests++; if (value !== 8'h2E || rdy !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midrst_rerun got val=%h rdy=%b busy=%b exp 2e 1 0", value, rdy, busy); end
    endtask

    task automatic test_zero_steps();
        apply_reset();
        start = 1; steps = 0;
        @(negedge clk);
        start = 0;
        tests++; if (rdy !== 1'b1 || busy !== 1'b0 || value !== 8'h97) begin fails++; $display("FAIL zero_steps got rdy=%b busy=%b val=%h exp 1 0 97", rdy, busy, value); end
        @(negedge clk);
        tests++; if (rdy !== 1'b1 || value !== 8'h97) begin fails++; $display("FAIL zero_hold got rdy=%b val=%h exp 1 97", rdy, value); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        start = 1; steps = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        start = 1; ack = 1; steps = 1;
        @(negedge clk);
        {start, ack} = 2'b00;
        tests++; if (busy !== 1'b1 || rdy !== 1'b0 || value !== 8'h2E) begin fails++; $display("FAIL b2b_restart got busy=%b rdy=%b val=%h exp 1 0 2e", busy, rdy, value); end
        @(negedge clk);
        tests++; if (rdy !== 1'b1 || value !== 8'h5C) begin fails++; $display("FAIL b2b_result got rdy=%b val=%h exp 1 5c", rdy, value); end
        start = 1; steps = 0;
        @(negedge clk);
        start = 0;
        tests++; if (rdy !== 1'b1 || busy !== 1'b0 || value !== 8'h5C) begin fails++; $display("FAIL b2b_zero got rdy=%b busy=%b val=%h exp 1 0 5c", rdy, busy, value); end
    endtask

    task automatic test_ignore_in_run();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h2E, 8'h5C, 8'hB8, 8'h70};
        apply_reset();
        start = 1; steps = 4;
        @(negedge clk);
        steps = 1; seed_load = 1; seed_in = 8'h11; ack = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (value !== exp_seq[i] || busy !== (i != 3)) begin fails++; $display("FAIL ignore_seq%0d got val=%h busy=%b exp %h %b", i, value, busy, exp_seq[i], i != 3); end
        end
        {start, seed_load, ack} = 3'b000;
        tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL ignore_rdy got %b exp 1", rdy); end
    endtask

    initial begin
        test_reset();
        test_step1();
        test_run4();
        test_ena_gap();
        test_seed();
        test_reset_mid_run();
        test_zero_steps();
        test_back_to_back();
        test_ignore_in_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
